// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the encryption and decryption datapaths.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        gf_mul3 = xtime(a) ^ a;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns on one 32-bit column; row 0 byte sits in the MSBs.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0_s, a1_s, a2_s, a3_s;

    assign {a0_s, a1_s, a2_s, a3_s} = col_i;

    assign col_o[31:24] = xtime(a0_s)   ^ gf_mul3(a1_s) ^ a2_s          ^ a3_s;
    assign col_o[23:16] = a0_s          ^ xtime(a1_s)   ^ gf_mul3(a2_s) ^ a3_s;
    assign col_o[15:8]  = a0_s          ^ a1_s          ^ xtime(a2_s)   ^ gf_mul3(a3_s);
    assign col_o[7:0]   = gf_mul3(a0_s) ^ a1_s          ^ a2_s          ^ xtime(a3_s);

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per cycle over four CALC cycles, valid/ready on both sides.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] col_q, col_d;
    logic       bypass_q, bypass_d;
    logic       out_valid_q, out_valid_d;
    aes_state_t work_q, work_d;

    logic       in_bypass_s;
    logic [31:0] col_word_s, col_mixed_s, col_new_s;
    aes_state_t work_upd_s;

    assign in_bypass_s = BYPASS_EN ? in_bypass : 1'b0;
    assign in_ready    = (state_q == ST_IDLE) && !rst;
    assign out_valid   = out_valid_q;
    assign out_state   = work_q;

    // Select the column currently being processed.
    always_comb begin
        col_word_s = 32'h0000_0000;
        case (col_q)
            2'd0:    col_word_s = work_q[127:96];
            2'd1:    col_word_s = work_q[95:64];
            2'd2:    col_word_s = work_q[63:32];
            2'd3:    col_word_s = work_q[31:0];
            default: col_word_s = 32'h0000_0000;
        endcase
    end

    mix_column_word u_mix_column_word (
        .col_i (col_word_s),
        .col_o (col_mixed_s)
    );

    assign col_new_s = bypass_q ? col_word_s : col_mixed_s;

    // Write the processed column back into its slot of the working state.
    always_comb begin
        work_upd_s = work_q;
        case (col_q)
            2'd0:    work_upd_s[127:96] = col_new_s;
            2'd1:    work_upd_s[95:64]  = col_new_s;
            2'd2:    work_upd_s[63:32]  = col_new_s;
            2'd3:    work_upd_s[31:0]   = col_new_s;
            default: work_upd_s         = work_q;
        endcase
    end

    // Next-state logic for the IDLE -> CALC x4 -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        bypass_d    = bypass_q;
        out_valid_d = out_valid_q;
        work_d      = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    work_d   = in_state;
                    bypass_d = in_bypass_s;
                    col_d    = 2'd0;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                work_d = work_upd_s;
                col_d  = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that discards any in-flight state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= 2'd0;
            bypass_q    <= 1'b0;
            out_valid_q <= 1'b0;
            work_q      <= 128'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            bypass_q    <= bypass_d;
            out_valid_q <= out_valid_d;
            work_q      <= work_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed self-checking bench for mix_columns_iter with hand-computed MixColumns vectors.
module tb_mix_columns_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int tests;
    int fails;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] CARRY_IN  = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] CARRY_OUT = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;

    mix_columns_iter #(.BYPASS_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one state from IDLE, scramble in_state after acceptance, wait for out_valid (bounded).
    task automatic run_one(input logic [127:0] st, input logic byp, output logic [127:0] res, output int lat, output logic rdy);
        rdy       = in_ready;
        in_valid  = 1'b1;
        in_state  = st;
        in_bypass = byp;
        step();
        in_valid  = 1'b0;
        in_state  = ~st;
        in_bypass = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        res = out_state;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++;
        if (out_state !== 128'h0) begin fails++; $display("FAIL reset_out_state got %h exp 0", out_state); end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
        step();
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat;
        logic rdy;
        run_one(FIPS_IN, 1'b0, res, lat, rdy);
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("FAIL fips_in_ready got %b exp 1", rdy); end
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL fips_latency got %0d exp 4", lat); end
        tests++;
        if (res !== FIPS_OUT) begin fails++; $display("FAIL fips_result got %h exp %h", res, FIPS_OUT); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL fips_done_in_ready got %b exp 0", in_ready); end
        drain();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL fips_handshake got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_columns();
        logic [127:0] res;
        int lat;
        logic rdy;
        run_one(COL_IN, 1'b0, res, lat, rdy);
        tests++;
        if (res !== COL_OUT) begin fails++; $display("FAIL columns_result got %h exp %h", res, COL_OUT); end
        drain();
        run_one(CARRY_IN, 1'b0, res, lat, rdy);
        tests++;
        if (res !== CARRY_OUT) begin fails++; $display("FAIL columns_carry got %h exp %h", res, CARRY_OUT); end
        drain();
    endtask

    task automatic test_bypass();
        logic [127:0] res;
        int lat;
        logic rdy;
        run_one(FIPS_IN, 1'b1, res, lat, rdy);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL bypass_latency got %0d exp 4", lat); end
        tests++;
        if (res !== FIPS_IN) begin fails++; $display("FAIL bypass_result got %h exp %h", res, FIPS_IN); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        int lat;
        logic rdy;
        int bad;
        run_one(COL_IN, 1'b0, res, lat, rdy);
        in_valid = 1'b1;
        in_state = FIPS_IN;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_state !== COL_OUT || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL backpressure_release got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL backpressure_ignored got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        logic rdy;
        int seen;
        in_valid = 1'b1;
        in_state = FIPS_IN;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready_during got %b exp 0", in_ready); end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0) begin
            fails++; $display("FAIL rstmid_after got valid=%b ready=%b state=%h exp 0/1/0", out_valid, in_ready, out_state);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL rstmid_no_output got %0d valid cycles exp 0", seen); end
        run_one(CARRY_IN, 1'b0, res, lat, rdy);
        tests++;
        if (lat !== 4 || res !== CARRY_OUT) begin
            fails++; $display("FAIL rstmid_next got lat=%0d res=%h exp 4 %h", lat, res, CARRY_OUT);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [127:0] outs [2];
        int when [2];
        int nacc;
        int nout;
        logic acc;
        logic ovh;
        logic [127:0] cap;
        nacc = 0;
        nout = 0;
        in_valid  = 1'b1;
        in_state  = FIPS_IN;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            acc = in_valid && in_ready;
            ovh = out_valid && out_ready;
            cap = out_state;
            step();
            if (acc) begin
                nacc++;
                if (nacc == 1) in_state = COL_IN;
                else in_valid = 1'b0;
            end
            if (ovh && nout < 2) begin
                outs[nout] = cap;
                when[nout] = c;
                nout++;
            end
        end
        out_ready = 1'b0;
        tests++;
        if (nout !== 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", nout); end
        else begin
            tests++;
            if (outs[0] !== FIPS_OUT) begin fails++; $display("FAIL b2b_first got %h exp %h", outs[0], FIPS_OUT); end
            tests++;
            if (outs[1] !== COL_OUT) begin fails++; $display("FAIL b2b_second got %h exp %h", outs[1], COL_OUT); end
            tests++;
            if (when[1] - when[0] !== 6) begin fails++; $display("FAIL b2b_spacing got %0d exp 6", when[1] - when[0]); end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fips();
        test_columns();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
